// File: rtl/load_store_unit.sv
// rtl/load_store_unit.sv - RV32I load/store unit with word-aligned memory port and load timeout
// Optional feature macro: LSU_MISALIGN_TRAP_EN (traps misaligned halfword/word accesses)
module load_store_unit #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_req_valid,
  output logic        o_req_ready,
  input  logic        i_is_store,
  input  logic [2:0]  i_funct3,
  input  logic [31:0] i_addr,
  input  logic [31:0] i_store_data,
  output logic        o_resp_valid,
  output logic        o_resp_err,
  output logic [31:0] o_load_data,
  output logic        o_mem_req_valid,
  input  logic        i_mem_req_ready,
  output logic        o_mem_we,
  output logic [31:0] o_mem_addr,
  output logic [31:0] o_mem_wdata,
  output logic [3:0]  o_mem_wstrb,
  input  logic        i_mem_rvalid,
  input  logic [31:0] i_mem_rdata
);

  localparam int CW = (TIMEOUT_CYCLES < 1) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT_CYCLES);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_RESP} state_t;

  state_t        r_state;
  state_t        w_next;
  logic          r_is_store;
  logic [2:0]    r_funct3;
  logic [1:0]    r_off;
  logic          r_err;
  logic [CW-1:0] r_cnt;

  logic          w_accept;
  logic          w_illegal;
  logic          w_misalign;
  logic          w_req_err;
  logic          w_limit;
  logic [31:0]   w_wdata;
  logic [3:0]    w_wstrb;
  logic [7:0]    w_byte;
  logic [15:0]   w_half;
  logic [31:0]   w_ext;

  assign w_accept  = i_req_valid && (r_state == S_IDLE);
  assign w_illegal = i_is_store ? (i_funct3 > 3'b010)
                                : (i_funct3 == 3'b011 || i_funct3 == 3'b110 || i_funct3 == 3'b111);

`ifdef LSU_MISALIGN_TRAP_EN
  assign w_misalign = ((i_funct3[1:0] == 2'b01) && i_addr[0]) ||
                      ((i_funct3[1:0] == 2'b10) && (i_addr[1:0] != 2'b00));
`else
  assign w_misalign = 1'b0;
`endif

  assign w_req_err = w_illegal || w_misalign;
  assign w_limit   = (r_cnt == LIMIT);

  // Place store data on its byte lanes and build the matching byte enables
  always_comb begin
    w_wdata = 32'h0;
    w_wstrb = 4'b0000;
    if (i_is_store && !w_req_err) begin
      case (i_funct3[1:0])
        2'b00: begin
          w_wdata = {4{i_store_data[7:0]}};
          w_wstrb = 4'b0001 << i_addr[1:0];
        end
        2'b01: begin
          w_wdata = {2{i_store_data[15:0]}};
          w_wstrb = 4'b0011 << {i_addr[1], 1'b0};
        end
        default: begin
          w_wdata = i_store_data;
          w_wstrb = 4'b1111;
        end
      endcase
    end
  end

  // Pick the addressed byte/halfword from the returned word and extend it
  always_comb begin
    w_byte = i_mem_rdata[7:0];
    case (r_off)
      2'd1:    w_byte = i_mem_rdata[15:8];
      2'd2:    w_byte = i_mem_rdata[23:16];
      2'd3:    w_byte = i_mem_rdata[31:24];
      default: w_byte = i_mem_rdata[7:0];
    endcase
    w_half = r_off[1] ? i_mem_rdata[31:16] : i_mem_rdata[15:0];
    w_ext  = 32'h0;
    case (r_funct3)
      3'b000:  w_ext = {{24{w_byte[7]}}, w_byte};
      3'b001:  w_ext = {{16{w_half[15]}}, w_half};
      3'b010:  w_ext = i_mem_rdata;
      3'b100:  w_ext = {24'h0, w_byte};
      3'b101:  w_ext = {16'h0, w_half};
      default: w_ext = 32'h0;
    endcase
  end

  // State register
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) r_state <= S_IDLE;
    else         r_state <= w_next;
  end

  // Next-state logic and state-decoded handshake outputs
  always_comb begin
    w_next          = r_state;
    o_req_ready     = 1'b0;
    o_mem_req_valid = 1'b0;
    o_mem_we        = 1'b0;
    o_resp_valid    = 1'b0;
    case (r_state)
      S_IDLE: begin
        o_req_ready = 1'b1;
        if (i_req_valid) w_next = w_req_err ? S_RESP : S_REQ;
      end
      S_REQ: begin
        o_mem_req_valid = 1'b1;
        o_mem_we        = r_is_store;
        if (i_mem_req_ready) w_next = r_is_store ? S_RESP : S_WAIT;
      end
      S_WAIT: begin
        if (i_mem_rvalid || w_limit) w_next = S_RESP;
      end
      S_RESP: begin
        o_resp_valid = 1'b1;
        w_next       = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  assign o_resp_err = r_err && (r_state == S_RESP);

  // Wait-cycle counter, cleared while the request is outstanding so WAIT starts at zero
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset)                 r_cnt <= '0;
    else if (r_state == S_REQ)   r_cnt <= '0;
    else if (r_state == S_WAIT && !w_limit) r_cnt <= r_cnt + CW'(1);
  end

  // Capture the request on acceptance and the load result or timeout in WAIT
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_is_store  <= 1'b0;
      r_funct3    <= 3'b000;
      r_off       <= 2'b00;
      r_err       <= 1'b0;
      o_mem_addr  <= 32'h0;
      o_mem_wdata <= 32'h0;
      o_mem_wstrb <= 4'b0000;
      o_load_data <= 32'h0;
    end else if (w_accept) begin
      r_is_store  <= i_is_store;
      r_funct3    <= i_funct3;
      r_off       <= i_addr[1:0];
      r_err       <= w_req_err;
      o_mem_addr  <= {i_addr[31:2], 2'b00};
      o_mem_wdata <= w_wdata;
      o_mem_wstrb <= w_wstrb;
      o_load_data <= 32'h0;
    end else if (r_state == S_WAIT) begin
      if (i_mem_rvalid) begin
        o_load_data <= w_ext;
        r_err       <= 1'b0;
      end else if (w_limit) begin
        o_load_data <= 32'h0;
        r_err       <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// tb/tb_load_store_unit.sv - self-checking bench for load_store_unit with a behavioural access model
module tb_load_store_unit;

  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid, req_ready, is_store;
  logic [2:0]  funct3;
  logic [31:0] addr, store_data;
  logic        resp_valid, resp_err;
  logic [31:0] load_data;
  logic        mem_req_valid, mem_req_ready, mem_we;
  logic [31:0] mem_addr, mem_wdata;
  logic [3:0]  mem_wstrb;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;

  int total = 0;
  int bad   = 0;

  load_store_unit #(.TIMEOUT_CYCLES(TO)) dut (
    .i_clk(clk), .i_reset(reset),
    .i_req_valid(req_valid), .o_req_ready(req_ready),
    .i_is_store(is_store), .i_funct3(funct3), .i_addr(addr), .i_store_data(store_data),
    .o_resp_valid(resp_valid), .o_resp_err(resp_err), .o_load_data(load_data),
    .o_mem_req_valid(mem_req_valid), .i_mem_req_ready(mem_req_ready), .o_mem_we(mem_we),
    .o_mem_addr(mem_addr), .o_mem_wdata(mem_wdata), .o_mem_wstrb(mem_wstrb),
    .i_mem_rvalid(mem_rvalid), .i_mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // Reference: what an RV32I LSU should return for one access
  function automatic void model(input bit st, input logic [2:0] f3, input logic [31:0] a,
                                input logic [31:0] sd, input logic [31:0] rd,
                                output bit err, output logic [31:0] ld,
                                output logic [31:0] wd, output logic [3:0] ws);
    int unsigned off, hoff;
    logic [31:0] b, h;
    off  = a % 4;
    hoff = (a / 2) % 2;
    err  = st ? (f3 > 2) : (f3 == 3 || f3 >= 6);
`ifdef LSU_MISALIGN_TRAP_EN
    begin
      int unsigned size;
      size = (f3 % 4 == 0) ? 1 : (f3 % 4 == 1) ? 2 : 4;
      if (a % size != 0) err = 1;
    end
`endif
    b  = (rd >> (8 * off)) & 32'hff;
    h  = (rd >> (16 * hoff)) & 32'hffff;
    ld = 0; wd = 0; ws = 0;
    if (!err) begin
      if (st) begin
        case (f3)
          3'd0: begin wd = (sd & 32'hff) * 32'h01010101;   ws = 4'(1 << off); end
          3'd1: begin wd = (sd & 32'hffff) * 32'h00010001; ws = 4'(3 << (2 * hoff)); end
          default: begin wd = sd; ws = 4'hf; end
        endcase
      end else begin
        case (f3)
          3'd0: ld = (b >= 128) ? b + 32'hffffff00 : b;
          3'd1: ld = (h >= 32768) ? h + 32'hffff0000 : h;
          3'd2: ld = rd;
          3'd4: ld = b;
          default: ld = h;
        endcase
      end
    end
  endfunction

  // One access: rdelay = cycles from handshake to rvalid (<0 = never); exp_lat > 0 pins latency
  task automatic run_access(input bit st, input logic [2:0] f3, input logic [31:0] a,
                            input logic [31:0] sd, input logic [31:0] rd, input bit zero_wait,
                            input int rdelay, input int exp_lat, input string tag);
    bit err, seen_req, rdy, to_exp;
    logic [31:0] ld, wd;
    logic [3:0] ws;
    int hs_t, resp_t;
    model(st, f3, a, sd, rd, err, ld, wd, ws);
    to_exp = !st && !err && rdelay < 0;
    if (to_exp) begin err = 1; ld = 0; end
    @(negedge clk);
    check({tag, " req_ready"}, 32'(req_ready), 32'd1);
    req_valid = 1; is_store = st; funct3 = f3; addr = a; store_data = sd;
    @(negedge clk);
    req_valid = 0; funct3 = 3'($urandom); addr = $urandom; store_data = $urandom;
    is_store = 1'($urandom);
    seen_req = 0; hs_t = -1; resp_t = -1;
    for (int t = 1; t < 80 && resp_t < 0; t++) begin
      if (resp_valid) begin
        resp_t = t;
      end else begin
        if (mem_req_valid) begin
          check({tag, " mem_addr"}, mem_addr, a & 32'hfffffffc);
          check({tag, " mem_we"}, 32'(mem_we), 32'(st));
          if (st && !seen_req) begin
            check({tag, " mem_wdata"}, mem_wdata, wd);
            check({tag, " mem_wstrb"}, 32'(mem_wstrb), 32'(ws));
          end
          seen_req = 1;
        end
        if (hs_t < 0) begin
          mem_rvalid = 1'($urandom);
          mem_rdata  = $urandom;
        end else if (!st && rdelay > 0 && t == hs_t + rdelay) begin
          mem_rvalid = 1; mem_rdata = rd;
        end else begin
          mem_rvalid = 0; mem_rdata = $urandom;
        end
        rdy = zero_wait ? 1'b1 : 1'($urandom);
        mem_req_ready = rdy;
        if (mem_req_valid && rdy && hs_t < 0) hs_t = t;
        @(negedge clk);
      end
    end
    mem_rvalid = 0; mem_req_ready = 0;
    if (resp_t < 0) begin
      check({tag, " resp_seen"}, 32'd0, 32'd1);
    end else begin
      check({tag, " resp_err"}, 32'(resp_err), 32'(err));
      check({tag, " load_data"}, load_data, ld);
      if (err && !to_exp) begin
        check({tag, " trap_latency"}, 32'(resp_t), 32'd1);
        check({tag, " no_mem_req"}, 32'(seen_req), 32'd0);
      end else if (exp_lat > 0) begin
        check({tag, " latency"}, 32'(resp_t), 32'(exp_lat));
      end
      if (to_exp)
        check({tag, " timeout_window"},
              32'(resp_t >= hs_t + TO + 1 && resp_t <= hs_t + TO + 2), 32'd1);
      @(negedge clk);
      check({tag, " resp_one_cycle"}, 32'(resp_valid), 32'd0);
      check({tag, " back_idle"}, 32'(req_ready), 32'd1);
    end
  endtask

  initial begin
    reset = 1; req_valid = 0; is_store = 0; funct3 = 0; addr = 0; store_data = 0;
    mem_req_ready = 0; mem_rvalid = 0; mem_rdata = 0;
    repeat (2) @(negedge clk);
    check("rst resp_valid", 32'(resp_valid), 0);
    check("rst resp_err", 32'(resp_err), 0);
    check("rst mem_req_valid", 32'(mem_req_valid), 0);
    check("rst mem_we", 32'(mem_we), 0);
    check("rst mem_wstrb", 32'(mem_wstrb), 0);
    check("rst mem_addr", mem_addr, 0);
    check("rst mem_wdata", mem_wdata, 0);
    check("rst load_data", load_data, 0);
    check("rst req_ready", 32'(req_ready), 1);
    reset = 0;

    run_access(1, 3'd2, 32'h100, 32'hdeadbeef, 0, 1, 1, 2, "sw_100");
    run_access(0, 3'd0, 32'h103, 0, 32'h80aabbcc, 1, 1, 3, "lb_103");
    run_access(0, 3'd4, 32'h103, 0, 32'h80aabbcc, 1, 1, 3, "lbu_103");
    run_access(1, 3'd1, 32'h202, 32'h1234abcd, 0, 1, 1, 2, "sh_202");
    run_access(0, 3'd2, 32'h104, 0, 32'h11111111, 1, -1, 0, "lw_timeout");
    run_access(0, 3'd2, 32'h102, 0, 32'hcafef00d, 1, 1, 3, "lw_102");
    run_access(0, 3'd2, 32'h108, 0, 32'h5a5a1234, 1, TO + 1, 0, "lw_data_at_limit");
    run_access(0, 3'd3, 32'h10c, 0, 0, 1, 1, 0, "ld_illegal");
    run_access(1, 3'd4, 32'h110, 32'h1, 0, 1, 1, 0, "sd_illegal");
    run_access(0, 3'd5, 32'h112, 0, 32'h8001ffff, 0, 2, 0, "lhu_hi");
    run_access(0, 3'd1, 32'h112, 0, 32'h8001ffff, 0, 2, 0, "lh_hi");

    // Reset while waiting for load data: no response may follow
    @(negedge clk);
    req_valid = 1; is_store = 0; funct3 = 3'd2; addr = 32'h104;
    @(negedge clk);
    req_valid = 0; mem_req_ready = 1;
    @(negedge clk);
    mem_req_ready = 0;
    reset = 1;
    @(negedge clk);
    reset = 0; mem_rvalid = 1; mem_rdata = 32'h12345678;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check("rst_wait no_resp", 32'(resp_valid), 0);
    end
    mem_rvalid = 0;
    check("rst_wait req_ready", 32'(req_ready), 1);

    for (int i = 0; i < 40; i++) begin
      bit st;
      logic [2:0] f3;
      st = 1'($urandom);
      f3 = ($urandom_range(0, 3) == 0) ? 3'($urandom) : (st ? 3'($urandom_range(0, 2))
                                                              : 3'($urandom_range(0, 5)));
      run_access(st, f3, $urandom, $urandom, $urandom, 1'($urandom),
                 ($urandom_range(0, 7) == 0) ? -1 : $urandom_range(1, 3), 0, "rand");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
